// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Scoreboard latency tracker: per-register pending/class/age state, issue-to-retire
// latency, per-class outstanding counts and max latency, protocol-error and timeout flags.

module vanilla_sbt_reg #(
    parameter int cls_w       = 2,
    parameter int age_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   set_i,
    input  logic                   clr_i,
    input  logic [cls_w-1:0]       set_class_i,
    output logic                   pending_o,
    output logic [cls_w-1:0]       class_o,
    output logic [age_width_p-1:0] age_o,
    output logic                   pend_nxt_o,
    output logic [cls_w-1:0]       class_nxt_o,
    output logic                   retire_o,
    output logic [age_width_p-1:0] lat_o
);
    logic [age_width_p-1:0] age_nxt;

    // A set wins over a clear to the same register: the old op retires, the new one starts fresh.
    always_comb begin
        pend_nxt_o  = pending_o;
        class_nxt_o = class_o;
        age_nxt     = age_o;
        if (set_i) begin
            pend_nxt_o  = 1'b1;
            class_nxt_o = set_class_i;
            age_nxt     = '0;
        end else if (clr_i) begin
            pend_nxt_o = 1'b0;
            age_nxt    = '0;
        end else if (pending_o && !(&age_o)) begin
            age_nxt = age_o + 1'b1;
        end
    end

    assign retire_o = clr_i && pending_o;
    assign lat_o    = (&age_o) ? age_o : age_o + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_o <= 1'b0;
            class_o   <= '0;
            age_o     <= '0;
        end else begin
            pending_o <= pend_nxt_o;
            class_o   <= class_nxt_o;
            age_o     <= age_nxt;
        end
    end
endmodule

module vanilla_scoreboard_latency_tracker #(
    parameter int reg_els_p     = 32,
    parameter int num_classes_p = 4,
    parameter int age_width_p   = 16,
    parameter int timeout_p     = 4096,
    parameter int ignore_reg0_p = 1,
    localparam int id_w  = (reg_els_p > 1) ? $clog2(reg_els_p) : 1,
    localparam int cls_w = (num_classes_p > 1) ? $clog2(num_classes_p) : 1,
    localparam int cnt_w = $clog2(reg_els_p + 1)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        set_v_i,
    input  logic [id_w-1:0]                             set_id_i,
    input  logic [cls_w-1:0]                            set_class_i,
    input  logic                                        clear_v_i,
    input  logic [id_w-1:0]                             clear_id_i,
    input  logic                                        stats_clear_i,
    output logic [reg_els_p-1:0][num_classes_p-1:0]     pending_o,
    output logic [num_classes_p-1:0][cnt_w-1:0]         outstanding_o,
    output logic [num_classes_p-1:0][age_width_p-1:0]   max_lat_o,
    output logic                                        retire_v_o,
    output logic [cls_w-1:0]                            retire_class_o,
    output logic [age_width_p-1:0]                      retire_lat_o,
    output logic                                        double_set_o,
    output logic                                        spurious_clear_o,
    output logic                                        timeout_o,
    output logic [id_w-1:0]                             timeout_id_o
);
    logic                                     set_ok, clr_ok;
    logic [reg_els_p-1:0]                     set_hit, clr_hit, pending_q, pend_nxt, retire;
    logic [reg_els_p-1:0][cls_w-1:0]          class_q, class_nxt;
    logic [reg_els_p-1:0][age_width_p-1:0]    age_q, lat;
    logic [num_classes_p-1:0][cnt_w-1:0]      out_nxt;
    logic                                     ret_v, dbl, clr_pending;
    logic [cls_w-1:0]                         ret_cls;
    logic [age_width_p-1:0]                   ret_lat;

    assign set_ok = set_v_i && (32'(set_id_i) < reg_els_p) &&
                    !((ignore_reg0_p != 0) && (set_id_i == '0));
    assign clr_ok = clear_v_i && (32'(clear_id_i) < reg_els_p) &&
                    !((ignore_reg0_p != 0) && (clear_id_i == '0));

    for (genvar g = 0; g < reg_els_p; g++) begin : g_reg
        assign set_hit[g] = set_ok && (set_id_i == id_w'(g));
        assign clr_hit[g] = clr_ok && (clear_id_i == id_w'(g));
        vanilla_sbt_reg #(.cls_w(cls_w), .age_width_p(age_width_p)) u_reg (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .set_i       (set_hit[g]),
            .clr_i       (clr_hit[g]),
            .set_class_i (set_class_i),
            .pending_o   (pending_q[g]),
            .class_o     (class_q[g]),
            .age_o       (age_q[g]),
            .pend_nxt_o  (pend_nxt[g]),
            .class_nxt_o (class_nxt[g]),
            .retire_o    (retire[g]),
            .lat_o       (lat[g])
        );
    end

    // At most one register matches clear_id, so the retire mux has a single winner.
    always_comb begin
        ret_v       = 1'b0;
        ret_cls     = '0;
        ret_lat     = '0;
        clr_pending = 1'b0;
        dbl         = 1'b0;
        for (int i = 0; i < reg_els_p; i++) begin
            if (retire[i]) begin
                ret_v   = 1'b1;
                ret_cls = class_q[i];
                ret_lat = lat[i];
            end
            if (clr_hit[i]) clr_pending = pending_q[i];
            if (set_hit[i] && pending_q[i] && !clr_hit[i]) dbl = 1'b1;
        end
    end

    always_comb begin
        pending_o = '0;
        out_nxt   = '0;
        for (int i = 0; i < reg_els_p; i++) begin
            for (int c = 0; c < num_classes_p; c++) begin
                pending_o[i][c] = pending_q[i] && (class_q[i] == cls_w'(c));
                if (pend_nxt[i] && (class_nxt[i] == cls_w'(c)))
                    out_nxt[c] = out_nxt[c] + cnt_w'(1);
            end
        end
    end

    // Scan downward so the lowest timed-out index is the one left standing.
    always_comb begin
        timeout_o    = 1'b0;
        timeout_id_o = '0;
        for (int i = reg_els_p - 1; i >= 0; i--) begin
            if (pending_q[i] && (age_q[i] >= age_width_p'(timeout_p))) begin
                timeout_o    = 1'b1;
                timeout_id_o = id_w'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_o    <= '0;
            max_lat_o        <= '0;
            retire_v_o       <= 1'b0;
            retire_class_o   <= '0;
            retire_lat_o     <= '0;
            double_set_o     <= 1'b0;
            spurious_clear_o <= 1'b0;
        end else begin
            outstanding_o    <= out_nxt;
            retire_v_o       <= ret_v;
            retire_class_o   <= ret_cls;
            retire_lat_o     <= ret_lat;
            double_set_o     <= dbl;
            spurious_clear_o <= clr_ok && !clr_pending;
            for (int c = 0; c < num_classes_p; c++) begin
                if (stats_clear_i)
                    max_lat_o[c] <= (ret_v && ret_cls == cls_w'(c)) ? ret_lat : '0;
                else if (ret_v && ret_cls == cls_w'(c) && ret_lat > max_lat_o[c])
                    max_lat_o[c] <= ret_lat;
            end
        end
    end
endmodule

// File: tb/tb_vanilla_scoreboard_latency_tracker.sv
// Directed bench: stimulus pushes expected retire/double-set/spurious events into a
// queue; a negedge monitor pops and compares whenever the DUT pulses one.

module tb_vanilla_scoreboard_latency_tracker;
    localparam int REGS = 32, NC = 4, AW = 16, TO = 8;
    localparam int IDW = 5, CW = 2, CNTW = 6;
    localparam int K_RET = 0, K_DBL = 1, K_SPU = 2;

    typedef struct {
        int kind;
        int cls;
        int lat;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1;
    logic set_v = 1'b0, clr_v = 1'b0, stats_clr = 1'b0;
    logic [IDW-1:0] set_id = '0, clr_id = '0;
    logic [CW-1:0]  set_cls = '0;
    logic [REGS-1:0][NC-1:0]  pending;
    logic [NC-1:0][CNTW-1:0]  outstanding;
    logic [NC-1:0][AW-1:0]    max_lat;
    logic           retire_v, double_set, spurious, timeout;
    logic [CW-1:0]  retire_cls;
    logic [AW-1:0]  retire_lat;
    logic [IDW-1:0] timeout_id;

    ev_t exp_q[$];
    int  total = 0, bad = 0;

    vanilla_scoreboard_latency_tracker #(
        .reg_els_p(REGS), .num_classes_p(NC), .age_width_p(AW),
        .timeout_p(TO), .ignore_reg0_p(1)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .set_v_i(set_v), .set_id_i(set_id), .set_class_i(set_cls),
        .clear_v_i(clr_v), .clear_id_i(clr_id), .stats_clear_i(stats_clr),
        .pending_o(pending), .outstanding_o(outstanding), .max_lat_o(max_lat),
        .retire_v_o(retire_v), .retire_class_o(retire_cls), .retire_lat_o(retire_lat),
        .double_set_o(double_set), .spurious_clear_o(spurious),
        .timeout_o(timeout), .timeout_id_o(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int cls, input int lat);
        ev_t e;
        e.kind = kind; e.cls = cls; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input int cls, input int lat);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d cls=%0d lat=%0d expected none", kind, cls, lat);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_RET && (e.cls != cls || e.lat != lat))) begin
                bad++;
                $display("FAIL event: got kind=%0d cls=%0d lat=%0d expected kind=%0d cls=%0d lat=%0d",
                         kind, cls, lat, e.kind, e.cls, e.lat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (retire_v)   pop_chk(K_RET, int'(retire_cls), int'(retire_lat));
        if (double_set) pop_chk(K_DBL, 0, 0);
        if (spurious)   pop_chk(K_SPU, 0, 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_set(input int id, input int cls);
        set_v = 1'b1; set_id = IDW'(id); set_cls = CW'(cls);
        cyc(1);
        set_v = 1'b0;
    endtask

    task automatic do_clear(input int id);
        clr_v = 1'b1; clr_id = IDW'(id);
        cyc(1);
        clr_v = 1'b0;
    endtask

    task automatic run_op(input int id, input int cls, input int l);
        do_set(id, cls);
        if (l > 1) cyc(l - 1);
        push(K_RET, cls, l);
        do_clear(id);
    endtask

    initial begin
        #2;
        chk("rst_pending", 64'(|pending), 0);
        chk("rst_outstanding", 64'(outstanding), 0);
        chk("rst_max_lat", 64'(max_lat), 0);
        chk("rst_pulses", {61'd0, retire_v, double_set, spurious}, 0);
        chk("rst_timeout", {58'd0, timeout, timeout_id}, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Basic set -> clear latency 7 in class 2
        do_set(5, 2);
        chk("pend5_onehot", 64'(pending[5]), 64'b0100);
        chk("out2_after_set", 64'(outstanding[2]), 1);
        cyc(6);
        push(K_RET, 2, 7);
        do_clear(5);
        chk("out2_after_clr", 64'(outstanding[2]), 0);
        chk("max_lat2", 64'(max_lat[2]), 7);

        // Double set overwrites class
        do_set(3, 1);
        cyc(1);
        push(K_DBL, 0, 0);
        do_set(3, 0);
        chk("pend3_onehot", 64'(pending[3]), 64'b0001);
        chk("out1_dbl", 64'(outstanding[1]), 0);
        chk("out0_dbl", 64'(outstanding[0]), 1);
        push(K_RET, 0, 1);
        do_clear(3);

        // Spurious clear, then same-cycle set+clear on a pending register
        push(K_SPU, 0, 0);
        do_clear(9);
        do_set(4, 1);
        cyc(3);
        set_v = 1'b1; set_id = 5'd4; set_cls = 2'd1;
        clr_v = 1'b1; clr_id = 5'd4;
        push(K_RET, 1, 4);
        cyc(1);
        set_v = 1'b0; clr_v = 1'b0;
        chk("pend4_still", 64'(pending[4]), 64'b0010);
        chk("out1_setclr", 64'(outstanding[1]), 1);
        push(K_RET, 1, 1);
        do_clear(4);

        // Timeout ordering
        do_set(2, 0);
        do_set(6, 0);
        cyc(6);
        chk("timeout_pre", 64'(timeout), 0);
        cyc(1);
        chk("timeout_hit", {58'd0, timeout, timeout_id}, {58'd0, 1'b1, 5'd2});
        cyc(1);
        push(K_RET, 0, 10);
        do_clear(2);
        chk("timeout_next", {58'd0, timeout, timeout_id}, {58'd0, 1'b1, 5'd6});
        push(K_RET, 0, 10);
        do_clear(6);
        chk("timeout_gone", {58'd0, timeout, timeout_id}, 0);
        chk("max_lat0", 64'(max_lat[0]), 10);

        // Max latency tracking and stats clear
        run_op(7, 3, 5);
        run_op(7, 3, 12);
        run_op(7, 3, 3);
        chk("max_lat3", 64'(max_lat[3]), 12);
        stats_clr = 1'b1;
        cyc(1);
        stats_clr = 1'b0;
        chk("stats_clear", 64'(max_lat), 0);

        // Register 0 is ignored
        do_set(0, 1);
        chk("reg0_pending", 64'(pending[0]), 0);
        chk("reg0_outstanding", 64'(outstanding), 0);
        do_clear(0);
        cyc(1);

        // Stats clear coinciding with a retire keeps that latency
        do_set(8, 2);
        cyc(1);
        push(K_RET, 2, 2);
        clr_v = 1'b1; clr_id = 5'd8; stats_clr = 1'b1;
        cyc(1);
        clr_v = 1'b0; stats_clr = 1'b0;
        chk("stats_retire", 64'(max_lat), {16'd0, 16'd2, 16'd0, 16'd0});

        // Async reset with ops in flight
        do_set(10, 0);
        do_set(11, 1);
        do_set(12, 2);
        do_set(13, 3);
        chk("out_inflight", 64'(outstanding), {6'd1, 6'd1, 6'd1, 6'd1});
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", 64'(|pending), 0);
        chk("mid_rst_out", 64'(outstanding), 0);
        chk("mid_rst_max", 64'(max_lat), 0);
        chk("mid_rst_misc", {59'd0, retire_v, double_set, spurious, timeout, |timeout_id}, 0);
        cyc(2);
        rst = 1'b0;
        cyc(12);
        chk("after_rst_pending", 64'(|pending), 0);

        cyc(2);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vanilla_scoreboard_latency_tracker.md
Name: vanilla_scoreboard_latency_tracker

Overview:
- Parametrised testbench-side scoreboard tracker for the vanilla core; generalises per-register pending bits to N op classes with per-register age counters.
- Records issue-to-retire latency, per-class outstanding counts and per-class max latency, and flags protocol errors and timeouts.
- Instantiated once for the int scoreboard and once for the float scoreboard, alongside the core; set strobes are already qualified by the core's stall/flush logic.

Parameters:
- reg_els_p, 32, number of tracked registers (ids 0..reg_els_p-1).
- num_classes_p, 4, number of op classes (e.g. div, dram load, global load, group load).
- age_width_p, 16, width of per-register age counter and latency outputs; saturating.
- timeout_p, 4096, age at or beyond which a pending register is reported as timed out; must be < 2^age_width_p.
- ignore_reg0_p, 1, when 1, sets and clears to id 0 are dropped (x0).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- set_v_i  in  1  issue strobe; an op with a scoreboarded destination leaves ID this cycle.
- set_id_i  in  clog2(reg_els_p)  destination register of issued op.
- set_class_i  in  clog2(num_classes_p)  class of issued op.
- clear_v_i  in  1  retire strobe (writeback clears scoreboard).
- clear_id_i  in  clog2(reg_els_p)  register being retired.
- stats_clear_i  in  1  synchronous clear of max-latency registers.
- pending_o  out  reg_els_p x num_classes_p  one-hot class pending per register.
- outstanding_o  out  num_classes_p x clog2(reg_els_p+1)  pending registers per class.
- max_lat_o  out  num_classes_p x age_width_p  max retired latency per class.
- retire_v_o  out  1  one-cycle pulse: a pending op retired.
- retire_class_o  out  clog2(num_classes_p)  class of retired op.
- retire_lat_o  out  age_width_p  latency of retired op.
- double_set_o  out  1  pulse: set to an already-pending register.
- spurious_clear_o  out  1  pulse: clear to a non-pending register.
- timeout_o  out  1  level: any register with age >= timeout_p.
- timeout_id_o  out  clog2(reg_els_p)  lowest-index timed-out register; 0 when timeout_o=0.

Behaviour:
- Reset (async, reset_i=1): all pending, class, age, outstanding, max_lat cleared; all outputs 0. Reset mid-operation drops all in-flight ops with no retire pulses.
- Per register state: pending_r, class_r, age_r. pending_o[i] = pending_r[i] ? onehot(class_r[i]) : 0.
- Set (cycle t): at edge, pending_r=1, class_r=set_class_i, age_r=0. Set to a pending register: overwrite class/age; double_set_o=1 next cycle; outstanding adjusted (old class -1, new class +1).
- Age: each cycle a register is pending and not being set, age_r += 1, saturating at 2^age_width_p-1.
- Clear of pending register: latency = sat(age_r+1); set at cycle t and clear at cycle t+L gives L (minimum 1). Registered outputs next cycle: retire_v_o=1, retire_class_o, retire_lat_o; max_lat_o[class] = max(max_lat_o, latency); pending_r=0; outstanding[class] -1.
- Clear of non-pending register: no state change, spurious_clear_o=1 next cycle.
- Simultaneous set and clear, same id, register pending: old op retires (latency reported), new op installed with age 0; no double_set. Register not pending: new op installed, spurious_clear_o=1.
- Simultaneous set and clear, different ids: both processed independently.
- outstanding_o: registered, never underflows or overflows by construction; equals popcount of pending_o column.
- stats_clear_i: max_lat_o <= 0 next edge; if retire in same cycle, max_lat_o <= that latency.
- ignore_reg0_p=1: set/clear with id 0 have no effect and raise no error pulses.
- timeout_o / timeout_id_o: combinational from age_r and pending_r; clears when the register retires or is re-set.
- Out-of-range ids (>= reg_els_p, non-power-of-two configurations): ignored.

Test Plan:
- Reset, set id 5 class 2 at cycle 10, clear id 5 at cycle 17 -> retire_v_o pulse cycle 18, retire_class_o=2, retire_lat_o=7, max_lat_o[2]=7, outstanding_o[2] 1->0.
- Set id 3 class 1, then set id 3 class 0 two cycles later -> double_set_o pulse; pending_o[3]=0001; outstanding_o[1]=0, [0]=1.
- Clear id 9 while idle -> spurious_clear_o pulse, no retire_v_o; same-cycle set+clear id 4 while pending at age 3 -> retire_lat_o=4, id 4 still pending, age 0.
- timeout_p=8, set ids 6 and 2 at cycle 0 -> at cycle 8 timeout_o=1, timeout_id_o=2; clear id 2 -> timeout_id_o=6.
- Retire latencies 5, 12, 3 in class 3 -> max_lat_o[3]=12; stats_clear_i -> 0; set/clear id 0 -> no effect, no pulses.
- Assert reset_i mid-flight, 4 pending ops, between clock edges -> all outputs 0 immediately, no retire pulse after release.
